// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: shared 640x480 timing defaults, phase encodings and a porch helper
package vga_timing_pkg;

   localparam int CNT_W = 10;

   localparam int   DEF_TOTAL_COLS      = 800;
   localparam int   DEF_TOTAL_ROWS      = 525;
   localparam int   DEF_ACTIVE_COLS     = 640;
   localparam int   DEF_ACTIVE_ROWS     = 480;
   localparam int   DEF_H_FRONT_PORCH   = 16;
   localparam int   DEF_H_SYNC_WIDTH    = 96;
   localparam int   DEF_V_FRONT_PORCH   = 10;
   localparam int   DEF_V_SYNC_WIDTH    = 2;
   localparam logic DEF_SYNC_ACTIVE_LVL = 1'b0;

   typedef logic [1:0] phase_t;

   localparam phase_t PH_ACTIVE = 2'd0;
   localparam phase_t PH_FRONT  = 2'd1;
   localparam phase_t PH_SYNC   = 2'd2;
   localparam phase_t PH_BACK   = 2'd3;

   function automatic int back_porch(input int total, input int active, input int front,
                                     input int sync_w);
      return total - active - front - sync_w;
   endfunction

endpackage

// File: rtl/vga_timing_axis.sv
// vga_timing_axis: one raster axis; owns the counter and reports the phase of the
// count being loaded so the parent can register syncs with zero skew to the count.
module vga_timing_axis
   import vga_timing_pkg::*;
#(
   parameter int TOTAL  = DEF_TOTAL_COLS,
   parameter int ACTIVE = DEF_ACTIVE_COLS,
   parameter int FRONT  = DEF_H_FRONT_PORCH,
   parameter int SYNC_W = DEF_H_SYNC_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             advance,
   output logic [CNT_W-1:0] count,
   output phase_t           phase,
   output logic             wrap
);

   localparam logic [CNT_W-1:0] LAST  = CNT_W'(TOTAL - 1);
   localparam logic [CNT_W-1:0] A_END = CNT_W'(ACTIVE);
   localparam logic [CNT_W-1:0] F_END = CNT_W'(ACTIVE + FRONT);
   localparam logic [CNT_W-1:0] S_END = CNT_W'(ACTIVE + FRONT + SYNC_W);

   logic [CNT_W-1:0] count_next;

   if (back_porch(TOTAL, ACTIVE, FRONT, SYNC_W) < 1) begin : g_bad_porch
      $error("vga_timing_axis: back porch %0d must be >= 1",
             back_porch(TOTAL, ACTIVE, FRONT, SYNC_W));
   end

   assign wrap       = count == LAST;
   assign count_next = !advance ? count : wrap ? '0 : count + 1'b1;

   assign phase = count_next < A_END ? PH_ACTIVE :
                  count_next < F_END ? PH_FRONT  :
                  count_next < S_END ? PH_SYNC   : PH_BACK;

   // Reset parks on the last blanking position so the first advance lands on 0.
   always_ff @(posedge clk or posedge rst)
      if (rst) count <= LAST;
      else     count <= count_next;

endmodule

// File: rtl/vga_sync_gen.sv
// vga_sync_gen: 640x480 VGA raster timing with registered syncs, counts, active
// flag and frame-start strobe, all aligned to the same pixel.
module vga_sync_gen
   import vga_timing_pkg::*;
#(
   parameter int   TOTAL_COLS      = DEF_TOTAL_COLS,
   parameter int   TOTAL_ROWS      = DEF_TOTAL_ROWS,
   parameter int   ACTIVE_COLS     = DEF_ACTIVE_COLS,
   parameter int   ACTIVE_ROWS     = DEF_ACTIVE_ROWS,
   parameter int   H_FRONT_PORCH   = DEF_H_FRONT_PORCH,
   parameter int   H_SYNC_WIDTH    = DEF_H_SYNC_WIDTH,
   parameter int   V_FRONT_PORCH   = DEF_V_FRONT_PORCH,
   parameter int   V_SYNC_WIDTH    = DEF_V_SYNC_WIDTH,
   parameter logic SYNC_ACTIVE_LVL = DEF_SYNC_ACTIVE_LVL
) (
   input  logic             i_Clk,
   input  logic             i_Rst,
   input  logic             i_Enable,
   output logic             o_HSync,
   output logic             o_VSync,
   output logic [CNT_W-1:0] o_Col_Count,
   output logic [CNT_W-1:0] o_Row_Count,
   output logic             o_Active,
   output logic             o_Frame_Start,
   output logic [7:0]       o_Frame_Count
);

   phase_t h_phase;
   phase_t v_phase;
   logic   h_wrap;
   logic   v_wrap;
   logic   frame_start;

   vga_timing_axis #(
      .TOTAL  (TOTAL_COLS),
      .ACTIVE (ACTIVE_COLS),
      .FRONT  (H_FRONT_PORCH),
      .SYNC_W (H_SYNC_WIDTH)
   ) u_h (
      .clk     (i_Clk),
      .rst     (i_Rst),
      .advance (i_Enable),
      .count   (o_Col_Count),
      .phase   (h_phase),
      .wrap    (h_wrap)
   );

   vga_timing_axis #(
      .TOTAL  (TOTAL_ROWS),
      .ACTIVE (ACTIVE_ROWS),
      .FRONT  (V_FRONT_PORCH),
      .SYNC_W (V_SYNC_WIDTH)
   ) u_v (
      .clk     (i_Clk),
      .rst     (i_Rst),
      .advance (i_Enable & h_wrap),
      .count   (o_Row_Count),
      .phase   (v_phase),
      .wrap    (v_wrap)
   );

   assign frame_start = i_Enable & h_wrap & v_wrap;

   // Phases describe the counts being loaded this edge, so flags match the counts.
   always_ff @(posedge i_Clk or posedge i_Rst)
      if (i_Rst) begin
         o_HSync       <= ~SYNC_ACTIVE_LVL;
         o_VSync       <= ~SYNC_ACTIVE_LVL;
         o_Active      <= 1'b0;
         o_Frame_Start <= 1'b0;
         o_Frame_Count <= '0;
      end else begin
         o_HSync       <= h_phase == PH_SYNC ? SYNC_ACTIVE_LVL : ~SYNC_ACTIVE_LVL;
         o_VSync       <= v_phase == PH_SYNC ? SYNC_ACTIVE_LVL : ~SYNC_ACTIVE_LVL;
         o_Active      <= h_phase == PH_ACTIVE && v_phase == PH_ACTIVE;
         o_Frame_Start <= frame_start;
         o_Frame_Count <= o_Frame_Count + {7'd0, frame_start};
      end

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen: directed checks of the default 640x480 timing plus a tiny raster
// instance used for whole-frame, vsync and frame-counter wrap checks.
module tb_vga_sync_gen;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       en = 1'b1;
   logic       en_s = 1'b0;
   logic       hs, vs, act, fs;
   logic [9:0] col, row;
   logic [7:0] fc;
   logic       s_hs, s_vs, s_act, s_fs;
   logic [9:0] s_col, s_row;
   logic [7:0] s_fc;

   int n_vec = 0;
   int n_miss = 0;

   always #5 clk = ~clk;

   vga_sync_gen dut (
      .i_Clk         (clk),
      .i_Rst         (rst),
      .i_Enable      (en),
      .o_HSync       (hs),
      .o_VSync       (vs),
      .o_Col_Count   (col),
      .o_Row_Count   (row),
      .o_Active      (act),
      .o_Frame_Start (fs),
      .o_Frame_Count (fc)
   );

   // 10x8 raster: hsync on cols 7..8, vsync on row 6, active 6x5.
   vga_sync_gen #(
      .TOTAL_COLS    (10),
      .TOTAL_ROWS    (8),
      .ACTIVE_COLS   (6),
      .ACTIVE_ROWS   (5),
      .H_FRONT_PORCH (1),
      .H_SYNC_WIDTH  (2),
      .V_FRONT_PORCH (1),
      .V_SYNC_WIDTH  (1)
   ) dut_s (
      .i_Clk         (clk),
      .i_Rst         (rst),
      .i_Enable      (en_s),
      .o_HSync       (s_hs),
      .o_VSync       (s_vs),
      .o_Col_Count   (s_col),
      .o_Row_Count   (s_row),
      .o_Active      (s_act),
      .o_Frame_Start (s_fs),
      .o_Frame_Count (s_fc)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_state();
      check("rst_col", col, 799);
      check("rst_row", row, 524);
      check("rst_hs", hs, 1);
      check("rst_vs", vs, 1);
      check("rst_act", act, 0);
      check("rst_fs", fs, 0);
      check("rst_fc", fc, 0);
   endtask

   task automatic check_first_pixel();
      check("first_col", col, 0);
      check("first_row", row, 0);
      check("first_act", act, 1);
      check("first_fs", fs, 1);
      check("first_fc", fc, 1);
      step();
      check("second_col", col, 1);
      check("second_fs", fs, 0);
      check("second_fc", fc, 1);
   endtask

   initial begin
      int mc, mr, mfc, last;
      logic mfs;
      step();
      step();
      check_reset_state();
      rst = 1'b0;
      step();
      check_first_pixel();
      check("row0_vs", vs, 1);
      for (int c = 1; c < 800; c++) begin
         check("scan_col", col, c);
         check("scan_act", act, c < 640 ? 1 : 0);
         check("scan_hs", hs, (c >= 656 && c < 752) ? 0 : 1);
         step();
      end
      check("wrap_col", col, 0);
      check("wrap_row", row, 1);
      check("wrap_hs", hs, 1);
      check("wrap_act", act, 1);
      check("wrap_fs", fs, 0);
      repeat (9 * 800 + 300) step();
      check("pre_hold_col", col, 300);
      check("pre_hold_row", row, 10);
      en = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step();
         check("hold_col", col, 300);
         check("hold_row", row, 10);
         check("hold_act", act, 1);
         check("hold_hs", hs, 1);
         check("hold_fs", fs, 0);
         check("hold_fc", fc, 1);
      end
      en = 1'b1;
      step();
      check("resume_col", col, 301);
      check("resume_row", row, 10);
      repeat (199) step();
      check("pre_rst_col", col, 500);
      #3 rst = 1'b1;
      #1 check_reset_state();
      step();
      check_reset_state();
      rst = 1'b0;
      step();
      check_first_pixel();

      mc = 9;
      mr = 7;
      mfc = 0;
      last = 0;
      check("s_idle_col", s_col, 9);
      check("s_idle_row", s_row, 7);
      check("s_idle_fc", s_fc, 0);
      en_s = 1'b1;
      for (int i = 1; i <= 256 * 80; i++) begin
         mfs = 1'b0;
         if (mc == 9) begin
            mc = 0;
            if (mr == 7) begin
               mr = 0;
               mfs = 1'b1;
            end else mr++;
         end else mc++;
         if (mfs) mfc = (mfc + 1) % 256;
         step();
         check("s_col", s_col, mc);
         check("s_row", s_row, mr);
         check("s_hs", s_hs, (mc == 7 || mc == 8) ? 0 : 1);
         check("s_vs", s_vs, mr == 6 ? 0 : 1);
         check("s_act", s_act, (mc < 6 && mr < 5) ? 1 : 0);
         check("s_fs", s_fs, mfs);
         if (mfs) begin
            check("s_fc", s_fc, mfc);
            if (last > 0) check("s_period", i - last, 80);
            last = i;
         end
      end
      check("s_fc_wrap", s_fc, 0);
      en_s = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         check("s_hold_col", s_col, 9);
         check("s_hold_row", s_row, 7);
         check("s_hold_fs", s_fs, 0);
      end
      en_s = 1'b1;
      step();
      check("s_resume_col", s_col, 0);
      check("s_resume_row", s_row, 0);
      check("s_resume_fs", s_fs, 1);
      check("s_resume_fc", s_fc, 1);
      step();
      check("s_resume_fs2", s_fs, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
